system_qsys_i2c_master: RTL and testbench



---
 rtl/system_qsys_i2c_master.sv | 245 ++++++++++++++++++++++++
 tb/tb_system_qsys_i2c_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/system_qsys_i2c_master.sv
// Avalon-MM byte-level I2C master: START, one byte plus ACK, STOP; SDA driven open-drain.
// Optional macro I2C_MASTER_CLK_STRETCH_EN makes scl open-drain and waits out slave clock stretching.
module system_qsys_i2c_master #(
  parameter logic [15:0] DEFAULT_PRESCALE = 16'd124
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
`ifdef I2C_MASTER_CLK_STRETCH_EN
  inout  wire         scl,
`else
  output logic        scl,
`endif
  inout  wire         sda
);

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  quarter_reg, quarter_next;
  logic [15:0] presc_cnt_reg, presc_cnt_next;
  logic [15:0] prescale_reg, prescale_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  rx_shift_reg, rx_shift_next;
  logic [7:0]  tx_byte_reg, tx_byte_next;
  logic [7:0]  rx_byte_reg, rx_byte_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        rxack_reg, rxack_next;
  logic        ack_bit_reg, ack_bit_next;
  logic        pend_byte_reg, pend_byte_next;
  logic        pend_stop_reg, pend_stop_next;
  logic        is_write_reg, is_write_next;
  logic        nack_reg, nack_next;
  logic        held_reg, held_next;
  logic        scl_reg, scl_next;
  logic        sda_lo_reg, sda_lo_next;
  logic [31:0] readdata_next;

  logic wr_en, stall, quarter_end, state_end, finish, sda_in;
  logic unused_writedata;

  assign unused_writedata = &{1'b0, writedata[31:16]};
  assign wr_en       = chipselect && !write_n;
  assign sda         = sda_lo_reg ? 1'b0 : 1'bz;
  assign sda_in      = sda;
  assign quarter_end = (presc_cnt_reg == prescale_reg) && !stall;
  assign state_end   = quarter_end && (quarter_reg == 2'd3);

`ifdef I2C_MASTER_CLK_STRETCH_EN
  logic [1:0] scl_sync_reg;

  assign scl = scl_reg ? 1'bz : 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) scl_sync_reg <= 2'b11;
    else          scl_sync_reg <= {scl_sync_reg[0], scl};
  end

  // Hold the high quarter until the released line is actually seen high.
  assign stall = (state_reg != IDLE) && (quarter_reg == 2'd1) && !scl_sync_reg[1];
`else
  assign scl   = scl_reg;
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      quarter_reg   <= 2'd0;
      presc_cnt_reg <= 16'd0;
      prescale_reg  <= DEFAULT_PRESCALE;
      bit_cnt_reg   <= 3'd0;
      rx_shift_reg  <= 8'd0;
      tx_byte_reg   <= 8'd0;
      rx_byte_reg   <= 8'd0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      rxack_reg     <= 1'b1;
      ack_bit_reg   <= 1'b1;
      pend_byte_reg <= 1'b0;
      pend_stop_reg <= 1'b0;
      is_write_reg  <= 1'b0;
      nack_reg      <= 1'b0;
      held_reg      <= 1'b0;
      scl_reg       <= 1'b1;
      sda_lo_reg    <= 1'b0;
      readdata      <= 32'd0;
    end else begin
      state_reg     <= state_next;
      quarter_reg   <= quarter_next;
      presc_cnt_reg <= presc_cnt_next;
      prescale_reg  <= prescale_next;
      bit_cnt_reg   <= bit_cnt_next;
      rx_shift_reg  <= rx_shift_next;
      tx_byte_reg   <= tx_byte_next;
      rx_byte_reg   <= rx_byte_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      rxack_reg     <= rxack_next;
      ack_bit_reg   <= ack_bit_next;
      pend_byte_reg <= pend_byte_next;
      pend_stop_reg <= pend_stop_next;
      is_write_reg  <= is_write_next;
      nack_reg      <= nack_next;
      held_reg      <= held_next;
      scl_reg       <= scl_next;
      sda_lo_reg    <= sda_lo_next;
      readdata      <= readdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    quarter_next   = quarter_reg;
    presc_cnt_next = presc_cnt_reg;
    prescale_next  = prescale_reg;
    bit_cnt_next   = bit_cnt_reg;
    rx_shift_next  = rx_shift_reg;
    tx_byte_next   = tx_byte_reg;
    rx_byte_next   = rx_byte_reg;
    busy_next      = busy_reg;
    done_next      = done_reg;
    rxack_next     = rxack_reg;
    ack_bit_next   = ack_bit_reg;
    pend_byte_next = pend_byte_reg;
    pend_stop_next = pend_stop_reg;
    is_write_next  = is_write_reg;
    nack_next      = nack_reg;
    held_next      = held_reg;
    finish         = 1'b0;

    if (wr_en) begin
      case (address)
        2'd0: if (!busy_reg) tx_byte_next = writedata[7:0];
        2'd1: if (!busy_reg && (|writedata[3:0])) begin
          busy_next      = 1'b1;
          pend_byte_next = writedata[2] | writedata[3];
          pend_stop_next = writedata[1];
          is_write_next  = writedata[2];
          nack_next      = writedata[4];
          quarter_next   = 2'd0;
          presc_cnt_next = 16'd0;
          bit_cnt_next   = 3'd0;
          if (writedata[0])                     state_next = START;
          else if (writedata[2] | writedata[3]) state_next = BIT;
          else                                  state_next = STOP;
        end
        2'd2: done_next = 1'b0;
        default: if (!busy_reg) prescale_next = writedata[15:0];
      endcase
    end

    // CMD writes are locked out while active, so this section never fights the decode above.
    if (state_reg != IDLE) begin
      if (quarter_end) begin
        presc_cnt_next = 16'd0;
        quarter_next   = quarter_reg + 2'd1;
      end else if (!stall) begin
        presc_cnt_next = presc_cnt_reg + 16'd1;
      end

      if (quarter_end && (quarter_reg == 2'd1)) begin
        if (state_reg == BIT) rx_shift_next = {rx_shift_reg[6:0], sda_in};
        if (state_reg == ACK) ack_bit_next  = sda_in;
      end

      if (state_end) begin
        case (state_reg)
          START: begin
            held_next = 1'b1;
            if (pend_byte_reg) begin
              state_next   = BIT;
              bit_cnt_next = 3'd0;
            end else if (pend_stop_reg) begin
              state_next = STOP;
            end else begin
              finish = 1'b1;
            end
          end
          BIT: begin
            if (bit_cnt_reg == 3'd7) state_next = ACK;
            else                     bit_cnt_next = bit_cnt_reg + 3'd1;
          end
          ACK: begin
            held_next = 1'b1;
            if (pend_stop_reg) state_next = STOP;
            else               finish = 1'b1;
          end
          default: begin
            held_next = 1'b0;
            finish    = 1'b1;
          end
        endcase
      end

      if (finish) begin
        state_next = IDLE;
        busy_next  = 1'b0;
        done_next  = 1'b1;
        if (pend_byte_reg && is_write_reg)  rxack_next   = ack_bit_reg;
        if (pend_byte_reg && !is_write_reg) rx_byte_next = rx_shift_reg;
      end
    end
  end

  // Pin levels are registered from the next state so the pads never glitch.
  always_comb begin
    scl_next    = !held_next;
    sda_lo_next = 1'b0;
    case (state_next)
      START: begin
        scl_next    = (quarter_next != 2'd3);
        sda_lo_next = quarter_next[1];
      end
      BIT: begin
        scl_next    = (quarter_next == 2'd1) || (quarter_next == 2'd2);
        sda_lo_next = is_write_next && !tx_byte_next[3'd7 - bit_cnt_next];
      end
      ACK: begin
        scl_next    = (quarter_next == 2'd1) || (quarter_next == 2'd2);
        sda_lo_next = !is_write_next && !nack_next;
      end
      STOP: begin
        scl_next    = (quarter_next != 2'd0);
        sda_lo_next = (quarter_next != 2'd3);
      end
      default: ;
    endcase
  end

  always_comb begin
    case (address)
      2'd0:    readdata_next = {24'd0, rx_byte_reg};
      2'd2:    readdata_next = {29'd0, done_reg, rxack_reg, busy_reg};
      2'd3:    readdata_next = {16'd0, prescale_reg};
      default: readdata_next = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_system_qsys_i2c_master.sv
// Self-checking bench for system_qsys_i2c_master: directed and random transfers against a waveform model.
module tb_system_qsys_i2c_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  wire         scl;
  wire         sda;
  logic        slave_low = 1'b0;

  assign sda = slave_low ? 1'b0 : 1'bz;
  pullup (sda);

  system_qsys_i2c_master dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .scl        (scl),
    .sda        (sda)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Model of the bus-visible register state.
  logic        m_held;
  logic [7:0]  m_rx;
  logic        m_rxack;
  logic        m_done;
  logic [15:0] m_presc;

  // Expected per-cycle waveform of one transfer.
  logic exp_scl[$];
  logic exp_mlow[$];
  logic exp_slv[$];

  logic mon_en = 1'b0;
  logic mon_q[$];

  always @(posedge scl) if (mon_en) mon_q.push_back(sda);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_held  = 1'b0;
    m_rx    = 8'd0;
    m_rxack = 1'b1;
    m_done  = 1'b0;
    m_presc = 16'd124;
  endfunction

  // One bus state = four quarters, each p+1 cycles; pattern bit q applies to quarter q.
  function automatic void add_state(input logic [3:0] scl_pat, input logic [3:0] mlow_pat,
                                    input logic slv, input int p);
    for (int q = 0; q < 4; q++)
      for (int c = 0; c <= p; c++) begin
        exp_scl.push_back(scl_pat[q]);
        exp_mlow.push_back(mlow_pat[q]);
        exp_slv.push_back(slv);
      end
  endfunction

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic set_presc(input logic [15:0] p);
    wr(2'd3, {16'd0, p});
    m_presc = p;
  endtask

  task automatic run_xfer(input string nm, input logic [4:0] cmd, input logic [7:0] tx,
                          input logic slave_ack, input logic [7:0] slave_byte,
                          input logic lock, input int abort_at, input int exp_busy);
    int p, n, busy_cnt;
    logic wr_op, byte_op, held_after, addr2_prev;
    logic [31:0] d;

    exp_scl.delete(); exp_mlow.delete(); exp_slv.delete();
    p       = int'(m_presc);
    wr_op   = cmd[2];
    byte_op = cmd[2] | cmd[3];
    if (cmd[0]) add_state(4'b0111, 4'b1100, 1'b0, p);
    if (byte_op) begin
      for (int i = 0; i < 8; i++)
        add_state(4'b0110, {4{wr_op && !tx[7-i]}}, !wr_op && !slave_byte[7-i], p);
      add_state(4'b0110, {4{!wr_op && !cmd[4]}}, wr_op && slave_ack, p);
    end
    if (cmd[1]) add_state(4'b1110, 4'b0111, 1'b0, p);
    n = exp_scl.size();
    held_after = cmd[1] ? 1'b0 : ((cmd[0] || byte_op) ? 1'b1 : m_held);

    wr(2'd0, {24'd0, tx});
    mon_q.delete();
    mon_en = 1'b1;
    @(negedge clk);
    address = 2'd1; writedata = {27'd0, cmd}; chipselect = 1'b1; write_n = 1'b0;
    addr2_prev = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k <= n + 1; k++) begin
      @(negedge clk);
      if (lock && k == 2) begin
        address = 2'd0; writedata = 32'hFF; write_n = 1'b0;
      end else if (lock && k == 3) begin
        address = 2'd3; writedata = 32'd5; write_n = 1'b0;
      end else begin
        address = 2'd2; write_n = 1'b1;
      end
      slave_low = (k < n) ? exp_slv[k] : 1'b0;
      if (k == abort_at) begin
        slave_low = 1'b0;
        reset_n = 1'b0;
        #1;
        chk({nm, "_rst_scl"}, {31'd0, scl}, 32'd1);
        chk({nm, "_rst_sda"}, {31'd0, sda}, 32'd1);
        chk({nm, "_rst_rdata"}, readdata, 32'd0);
        model_reset();
        mon_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        $display("xfer %s cmd=%02h aborted by reset at cycle %0d", nm, cmd, k);
        return;
      end
      #1;
      chk({nm, "_scl"}, {31'd0, scl}, {31'd0, (k < n) ? exp_scl[k] : !held_after});
      chk({nm, "_sda"}, {31'd0, sda}, {31'd0, (k < n) ? !(exp_mlow[k] || exp_slv[k]) : 1'b1});
      if (k >= 1 && addr2_prev) begin
        chk({nm, "_busy"}, {31'd0, readdata[0]}, {31'd0, (k - 1 < n)});
        if (readdata[0]) busy_cnt++;
      end
      addr2_prev = lock ? (k >= 4) : 1'b1;
    end
    mon_en = 1'b0;

    m_held = held_after;
    m_done = 1'b1;
    if (byte_op && wr_op)  m_rxack = !slave_ack;
    if (byte_op && !wr_op) m_rx = slave_byte;
    if (exp_busy >= 0) chk({nm, "_busy_len"}, busy_cnt, exp_busy);
    rd(2'd2, d);
    chk({nm, "_status"}, d, {29'd0, m_done, m_rxack, 1'b0});
    rd(2'd0, d);
    chk({nm, "_rxbyte"}, d, {24'd0, m_rx});
    $display("xfer %s cmd=%02h presc=%0d tx=%02h cycles=%0d rx=%02h rxack=%0d",
             nm, cmd, p, tx, n, m_rx, m_rxack);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  bits;
    logic [4:0]  cmd;

    model_reset();
    #2 reset_n = 1'b0;
    #3;
    chk("reset_rdata", readdata, 32'd0);
    chk("reset_scl", {31'd0, scl}, 32'd1);
    chk("reset_sda", {31'd0, sda}, 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd(2'd3, d);
    chk("reset_presc", d, 32'd124);
    rd(2'd2, d);
    chk("reset_status", d, 32'h2);
    rd(2'd1, d);
    chk("cmd_reads_zero", d, 32'd0);
    $display("reset check done: prescale=%0d", 124);

    // Write transfer START+WRITE+STOP, slave ACKs
    set_presc(16'd0);
    run_xfer("write", 5'h07, 8'hA5, 1'b1, 8'h00, 1'b0, -1, 44);
    chk("write_rises", mon_q.size(), 10);
    if (mon_q.size() >= 9) begin
      bits = 8'd0;
      for (int i = 0; i < 8; i++) bits = {bits[6:0], mon_q[i]};
      chk("write_bits", {24'd0, bits}, 32'hA5);
      chk("write_ackbit", {31'd0, mon_q[8]}, 32'd0);
    end
    rd(2'd2, d);
    chk("write_status_lit", d, 32'h4);

    // Read transfer with NACK, slave returns 0x3C
    run_xfer("read", 5'h18, 8'h00, 1'b0, 8'h3C, 1'b0, -1, 36);
    chk("read_rises", mon_q.size(), 9);
    if (mon_q.size() >= 9) chk("read_nack_slot", {31'd0, mon_q[8]}, 32'd1);
    rd(2'd0, d);
    chk("read_data_lit", d, 32'h3C);

    // Byte write with no slave present
    run_xfer("noack", 5'h04, 8'h81, 1'b0, 8'h00, 1'b0, -1, 36);
    rd(2'd2, d);
    chk("noack_status_lit", d, 32'h6);
    wr(2'd2, 32'd0);
    m_done = 1'b0;
    rd(2'd2, d);
    chk("clear_done_lit", d, 32'h2);

    // Lockout: DATA/PRESCALE writes during BUSY must be ignored
    set_presc(16'd2);
    run_xfer("lockout", 5'h06, 8'h5A, 1'b1, 8'h00, 1'b1, -1, -1);
    rd(2'd3, d);
    chk("lockout_presc_lit", d, 32'd2);

    // Reset mid-byte
    set_presc(16'd1);
    run_xfer("midreset", 5'h05, 8'h33, 1'b1, 8'h00, 1'b0, 13, -1);
    rd(2'd3, d);
    chk("midreset_presc", d, 32'd124);
    rd(2'd2, d);
    chk("midreset_status", d, 32'h2);

    // Randomized transfers
    for (int t = 0; t < 24; t++) begin
      set_presc(16'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) begin
        wr(2'd2, 32'd0);
        m_done = 1'b0;
      end
      cmd = 5'($urandom_range(0, 31));
      if (cmd[3:0] == 4'd0) cmd[1] = 1'b1;
      run_xfer($sformatf("rand%0d", t), cmd, 8'($urandom), 1'($urandom_range(0, 1)),
               8'($urandom), 1'b0, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
